// File: rtl/shared_reg_arbiter_pkg.sv
// Shared constants, FSM encoding and round-robin helper for the shared register arbiter.
package shared_reg_arbiter_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGrant = 2'b01,
    StWrite = 2'b10
  } state_e;

  // Search starts one past the last winner and wraps, so the previous winner is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + i[1:0];
      if (req[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_en_reg.sv
// Shared data register with enable and synchronous clear; clear has priority over a load.
module en_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one of four requesters a single write to a shared register.
module shared_reg_arbiter #(
  parameter int unsigned N_REQ = shared_reg_arbiter_pkg::N_REQ,
  parameter int unsigned WIDTH = shared_reg_arbiter_pkg::WIDTH
) (
  input  logic                   sra_port_clk,
  input  logic                   sra_port_rst,
  input  logic [N_REQ-1:0]       sra_port_req,
  input  logic [N_REQ*WIDTH-1:0] sra_port_data,
  input  logic                   sra_port_clr,
  output logic [N_REQ-1:0]       sra_oport_gnt,
  output logic [N_REQ-1:0]       sra_oport_ack,
  output logic [1:0]             sra_oport_gidx,
  output logic                   sra_oport_busy,
  output logic [WIDTH-1:0]       sra_oport_q
);

  import shared_reg_arbiter_pkg::*;

  state_e           r_state;
  state_e           w_state_next;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_next;
  logic [1:0]       r_gidx;
  logic [1:0]       w_gidx_next;
  logic             w_load;
  logic [WIDTH-1:0] w_slice;

  always_ff @(posedge sra_port_clk or posedge sra_port_rst) begin
    if (sra_port_rst) begin
      r_state <= StIdle;
      r_ptr   <= 2'd3;
      r_gidx  <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_gidx  <= w_gidx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_gidx_next  = r_gidx;
    w_load       = 1'b0;
    case (r_state)
      StIdle: begin
        if (|sra_port_req) begin
          w_gidx_next  = rr_pick(sra_port_req[3:0], r_ptr);
          w_state_next = StGrant;
        end
      end
      StGrant: begin
        // A requester that withdrew during its grant forfeits it; ptr stays put.
        if (sra_port_req[r_gidx]) begin
          w_load       = 1'b1;
          w_state_next = StWrite;
        end else begin
          w_state_next = StIdle;
        end
      end
      StWrite: begin
        w_ptr_next   = r_gidx;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decode from registered state only, so req never reaches gnt combinationally.
  always_comb begin
    sra_oport_gnt = '0;
    sra_oport_ack = '0;
    if (r_state == StGrant) begin
      sra_oport_gnt[r_gidx] = 1'b1;
    end
    if (r_state == StWrite) begin
      sra_oport_ack[r_gidx] = 1'b1;
    end
  end

  assign sra_oport_busy = (r_state != StIdle);
  assign sra_oport_gidx = r_gidx;
  assign w_slice        = sra_port_data[WIDTH*r_gidx +: WIDTH];

  en_reg #(
    .WIDTH(WIDTH)
  ) u_en_reg (
    .clk(sra_port_clk),
    .rst(sra_port_rst),
    .clr(sra_port_clr),
    .en (w_load),
    .d  (w_slice),
    .q  (sra_oport_q)
  );

endmodule
